// File: rtl/iterative_divider_if.sv
// Handshake and operand/result bundle between the pipeline and the iterative divider.
// The pipeline is the master; the divider is the slave.
`timescale 1ns/1ps
interface iterative_divider_if #(
  parameter int WORD_LENGTH = 32
) ();
  logic                   start;
  logic                   is_signed;
  logic [WORD_LENGTH-1:0] dividend;
  logic [WORD_LENGTH-1:0] divisor;
  logic                   busy;
  logic                   done;
  logic [WORD_LENGTH-1:0] quotient;
  logic [WORD_LENGTH-1:0] remainder;
  logic                   div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/iterative_divider.sv
// Multicycle restoring divider for DIV/DIVU: quotient goes to LO, remainder goes to HI.
// It produces one quotient bit per clock on operand magnitudes, then applies a sign fix.
`timescale 1ns/1ps
module iterative_divider #(
  parameter int WORD_LENGTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  iterative_divider_if.slave   dif
);

  // state    | meaning
  // S_IDLE   | waiting for start; results held
  // S_DIVIDE | one restoring iteration per edge, count 0..WORD_LENGTH-1
  // S_FINISH | sign fix / divide-by-zero result, pulse done
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  localparam int CW = $clog2(WORD_LENGTH);

  state_t                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic [WORD_LENGTH-1:0] rem_q, rem_d;
  logic [WORD_LENGTH-1:0] quo_q, quo_d;
  logic [WORD_LENGTH-1:0] dvsr_q, dvsr_d;
  logic                   qneg_q, qneg_d;
  logic                   rneg_q, rneg_d;
  logic                   dbz_q, dbz_d;
  logic [WORD_LENGTH-1:0] quotient_q, quotient_d;
  logic [WORD_LENGTH-1:0] remainder_q, remainder_d;
  logic                   div_by_zero_q, div_by_zero_d;
  logic                   done_q, done_d;

  logic                   dvnd_neg;
  logic                   dvsr_neg;
  logic [WORD_LENGTH-1:0] dvnd_mag;
  logic [WORD_LENGTH-1:0] dvsr_mag;
  logic [WORD_LENGTH:0]   rem_shift;
  logic [WORD_LENGTH:0]   trial;

  assign dvnd_neg = dif.is_signed & dif.dividend[WORD_LENGTH-1];
  assign dvsr_neg = dif.is_signed & dif.divisor[WORD_LENGTH-1];
  assign dvnd_mag = dvnd_neg ? -dif.dividend : dif.dividend;
  assign dvsr_mag = dvsr_neg ? -dif.divisor  : dif.divisor;

  // rem < divisor always holds, so the top bit of trial is a clean borrow flag.
  assign rem_shift = {rem_q, quo_q[WORD_LENGTH-1]};
  assign trial     = rem_shift - {1'b0, dvsr_q};

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    dvsr_d        = dvsr_q;
    qneg_d        = qneg_q;
    rneg_d        = rneg_q;
    dbz_d         = dbz_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    done_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (dif.start) begin
          rem_d   = '0;
          count_d = '0;
          if (dif.divisor == '0) begin
            // The raw dividend is parked in quo so it can be returned as the remainder.
            dbz_d   = 1'b1;
            quo_d   = dif.dividend;
            dvsr_d  = '0;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            state_d = S_FINISH;
          end else begin
            dbz_d   = 1'b0;
            quo_d   = dvnd_mag;
            dvsr_d  = dvsr_mag;
            qneg_d  = dvnd_neg ^ dvsr_neg;
            rneg_d  = dvnd_neg;
            state_d = S_DIVIDE;
          end
        end
      end

      S_DIVIDE: begin
        if (trial[WORD_LENGTH]) begin
          rem_d = rem_shift[WORD_LENGTH-1:0];
        end else begin
          rem_d = trial[WORD_LENGTH-1:0];
        end
        quo_d = {quo_q[WORD_LENGTH-2:0], ~trial[WORD_LENGTH]};
        if (count_q == CW'(WORD_LENGTH - 1)) begin
          state_d = S_FINISH;
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      S_FINISH: begin
        if (dbz_q) begin
          quotient_d  = '1;
          remainder_d = quo_q;
        end else begin
          quotient_d  = qneg_q ? -quo_q : quo_q;
          remainder_d = rneg_q ? -rem_q : rem_q;
        end
        div_by_zero_d = dbz_q;
        done_d        = 1'b1;
        state_d       = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvsr_q        <= '0;
      qneg_q        <= 1'b0;
      rneg_q        <= 1'b0;
      dbz_q         <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      dvsr_q        <= dvsr_d;
      qneg_q        <= qneg_d;
      rneg_q        <= rneg_d;
      dbz_q         <= dbz_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
      done_q        <= done_d;
    end
  end

  assign dif.busy        = (state_q != S_IDLE);
  assign dif.done        = done_q;
  assign dif.quotient    = quotient_q;
  assign dif.remainder   = remainder_q;
  assign dif.div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: a table of vectors plus random ops through a scoreboard,
// with hand-written sequences for handshake, back-to-back and mid-op reset.
`timescale 1ns/1ps
module tb_iterative_divider;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;

  iterative_divider_if #(.WORD_LENGTH(W)) dif ();

  iterative_divider #(.WORD_LENGTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .dif   (dif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  exp_t scb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    int   sa;
    int   sd;
    if (b == '0) begin
      e.q = '1; e.r = a; e.z = 1'b1;
    end else if (s) begin
      sa = a; sd = b;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.q = a; e.r = '0;
      end else begin
        e.q = sa / sd; e.r = sa % sd;
      end
      e.z = 1'b0;
    end else begin
      e.q = a / b; e.r = a % b; e.z = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard side: every done pulse pops one expectation.
  always @(negedge clk) begin
    if (!reset && dif.done) begin
      done_cnt++;
      check("busy_with_done", {31'b0, dif.busy}, '0);
      if (scb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
      end else begin
        mon_e = scb.pop_front();
        check("quotient", dif.quotient, mon_e.q);
        check("remainder", dif.remainder, mon_e.r);
        check("div_by_zero", {31'b0, dif.div_by_zero}, {31'b0, mon_e.z});
      end
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input exp_t e, input string name);
    int n;
    int busy_n;
    dif.start = 1'b1; dif.dividend = a; dif.divisor = b; dif.is_signed = s;
    scb.push_back(e);
    @(posedge clk); #1;
    dif.start = 1'b0; dif.dividend = $urandom; dif.divisor = $urandom; dif.is_signed = 1'($urandom);
    n = 0;
    busy_n = dif.busy ? 1 : 0;
    while (!dif.done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (dif.busy) busy_n++;
    end
    check({name, "_latency"}, n, (b == '0) ? 1 : W + 1);
    check({name, "_busy_cycles"}, busy_n, (b == '0) ? 1 : W + 1);
    @(posedge clk); #1;
  endtask

  vec_t vecs[12];
  exp_t e;
  int   base;
  int   n;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0};
    vecs[1]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    vecs[2]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0};
    vecs[3]  = '{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          1'b1};
    vecs[4]  = '{32'd9,          32'd3,          1'b0, 32'd3,          32'd0,          1'b0};
    vecs[5]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0};
    vecs[6]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0};
    vecs[7]  = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0};
    vecs[8]  = '{32'hFFFF_FFF9,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1};
    vecs[9]  = '{32'd3,          32'd10,         1'b0, 32'd0,          32'd3,          1'b0};
    vecs[10] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 32'd1,          32'd0,          1'b0};
    vecs[11] = '{32'hFFFF_FF9C,  32'd7,          1'b1, 32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0};

    dif.start = 1'b0; dif.is_signed = 1'b0; dif.dividend = '0; dif.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'b0, dif.busy}, '0);
    check("reset_done", {31'b0, dif.done}, '0);
    check("reset_quotient", dif.quotient, '0);
    check("reset_remainder", dif.remainder, '0);
    check("reset_dbz", {31'b0, dif.div_by_zero}, '0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      e.q = vecs[i].q; e.r = vecs[i].r; e.z = vecs[i].z;
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, e, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rs;
      ra = $urandom;
      rb = (i % 2 == 0) ? W'($urandom_range(1, 1000)) : W'($urandom);
      rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs, model(ra, rb, rs), $sformatf("rnd%0d", i));
    end

    // Start pulses during a busy op must be ignored.
    base = done_cnt;
    dif.start = 1'b1; dif.dividend = 32'd100; dif.divisor = 32'd7; dif.is_signed = 1'b0;
    scb.push_back(model(32'd100, 32'd7, 1'b0));
    @(posedge clk); #1;
    dif.start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 5 || c == 20) begin
        dif.start = 1'b1; dif.dividend = 32'd50; dif.divisor = 32'd5;
      end else begin
        dif.start = 1'b0;
      end
    end
    check("ignored_start_done_count", done_cnt - base, 1);
    check("hold_quotient", dif.quotient, 32'd14);
    check("hold_remainder", dif.remainder, 32'd2);
    check("idle_after_ignored", {31'b0, dif.busy}, '0);

    // Start held high through done: the second op is accepted on the edge after done.
    dif.start = 1'b1; dif.dividend = 32'd20; dif.divisor = 32'd4; dif.is_signed = 1'b0;
    scb.push_back(model(32'd20, 32'd4, 1'b0));
    @(posedge clk); #1;
    n = 0;
    while (!dif.done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_first_latency", n, W + 1);
    dif.dividend = 32'd1000; dif.divisor = 32'd7;
    scb.push_back(model(32'd1000, 32'd7, 1'b0));
    @(posedge clk); #1;
    dif.start = 1'b0;
    check("b2b_second_busy", {31'b0, dif.busy}, 32'd1);
    n = 0;
    while (!dif.done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_second_latency", n, W + 1);
    @(posedge clk); #1;

    // Reset at iteration 10 discards the op immediately and without a done.
    dif.start = 1'b1; dif.dividend = 32'd1000; dif.divisor = 32'd3; dif.is_signed = 1'b0;
    @(posedge clk); #1;
    dif.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    base = done_cnt;
    reset = 1'b1;
    #1;
    check("midop_reset_busy", {31'b0, dif.busy}, '0);
    check("midop_reset_done", {31'b0, dif.done}, '0);
    check("midop_reset_quotient", dif.quotient, '0);
    check("midop_reset_remainder", dif.remainder, '0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("no_done_after_reset", done_cnt - base, 0);
    e.q = 32'd333; e.r = 32'd1; e.z = 1'b0;
    run_op(32'd1000, 32'd3, 1'b0, e, "post_reset");

    check("scoreboard_empty", scb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
